// File: rtl/rvfi_mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package rvfi_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_e;

  typedef enum logic {
    GNT_I,
    GNT_D
  } arb_grant_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_timer.sv
// BUSY-cycle counter; flags the last allowed cycle of an outstanding memory request.
module mem_arb_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      logic [TW-1:0] timer;

      always_ff @(posedge clock) begin
        if (reset || clear) begin
          timer <= '0;
        end else if (enable) begin
          timer <= timer + TW'(1);
        end
      end

      // Expiry is the (TIMEOUT)th BUSY cycle, i.e. timer == TIMEOUT-1.
      assign expired = enable && (timer == TW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/rvfi_mem_arbiter.sv
// Shares one picorv32-style memory port between fetch and data ports:
// data has priority, fetches win after MAX_WAIT consecutive losses.
module rvfi_mem_arbiter
  import rvfi_mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_imem_valid,
  input  logic [31:0] io_imem_addr,
  output logic        io_imem_ready,
  output logic [31:0] io_imem_rdata,
  input  logic        io_dmem_valid,
  input  logic [31:0] io_dmem_addr,
  input  logic [31:0] io_dmem_wdata,
  input  logic [3:0]  io_dmem_wstrb,
  output logic        io_dmem_ready,
  output logic [31:0] io_dmem_rdata,
  output logic        io_err,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  arb_state_e    state;
  arb_grant_e    grant;
  arb_grant_e    grant_next;
  mem_req_t      req_next;
  logic [WW-1:0] wait_cnt;
  logic          expired;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (state == IDLE),
    .enable  (state == BUSY),
    .expired (expired)
  );

  always_comb begin
    grant_next = GNT_D;
    if (io_imem_valid && (!io_dmem_valid || wait_cnt == WW'(MAX_WAIT))) begin
      grant_next = GNT_I;
    end
    req_next = '0;
    if (grant_next == GNT_I) begin
      req_next.addr = io_imem_addr;
    end else begin
      req_next.addr  = io_dmem_addr;
      req_next.wdata = io_dmem_wdata;
      req_next.wstrb = io_dmem_wstrb;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= GNT_I;
      wait_cnt      <= '0;
      mem_valid     <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wstrb     <= '0;
      io_imem_ready <= 1'b0;
      io_imem_rdata <= '0;
      io_dmem_ready <= 1'b0;
      io_dmem_rdata <= '0;
      io_err        <= 1'b0;
    end else begin
      // Response outputs are single-cycle pulses unless set below.
      io_imem_ready <= 1'b0;
      io_imem_rdata <= '0;
      io_dmem_ready <= 1'b0;
      io_dmem_rdata <= '0;
      io_err        <= 1'b0;
      case (state)
        IDLE: begin
          if (io_imem_valid || io_dmem_valid) begin
            state     <= BUSY;
            grant     <= grant_next;
            mem_valid <= 1'b1;
            mem_addr  <= req_next.addr;
            mem_wdata <= req_next.wdata;
            mem_wstrb <= req_next.wstrb;
            if (grant_next == GNT_I) begin
              wait_cnt <= '0;
            end else if (io_imem_valid && wait_cnt != WW'(MAX_WAIT)) begin
              wait_cnt <= wait_cnt + WW'(1);
            end
          end
        end
        BUSY: begin
          // A completion coinciding with expiry is treated as a success.
          if (mem_ready || expired) begin
            state     <= RESP;
            mem_valid <= 1'b0;
            io_err    <= !mem_ready;
            if (grant == GNT_I) begin
              io_imem_ready <= 1'b1;
              io_imem_rdata <= mem_ready ? mem_rdata : 32'h0;
            end else begin
              io_dmem_ready <= 1'b1;
              io_dmem_rdata <= mem_ready ? mem_rdata : 32'h0;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rvfi_mem_arbiter.sv
// Directed bench for rvfi_mem_arbiter (MAX_WAIT=4, TIMEOUT=8).
module tb_rvfi_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        io_imem_valid;
  logic [31:0] io_imem_addr;
  logic        io_imem_ready;
  logic [31:0] io_imem_rdata;
  logic        io_dmem_valid;
  logic [31:0] io_dmem_addr;
  logic [31:0] io_dmem_wdata;
  logic [3:0]  io_dmem_wstrb;
  logic        io_dmem_ready;
  logic [31:0] io_dmem_rdata;
  logic        io_err;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  rvfi_mem_arbiter #(.MAX_WAIT(4), .TIMEOUT(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .io_imem_valid (io_imem_valid),
    .io_imem_addr  (io_imem_addr),
    .io_imem_ready (io_imem_ready),
    .io_imem_rdata (io_imem_rdata),
    .io_dmem_valid (io_dmem_valid),
    .io_dmem_addr  (io_dmem_addr),
    .io_dmem_wdata (io_dmem_wdata),
    .io_dmem_wstrb (io_dmem_wstrb),
    .io_dmem_ready (io_dmem_ready),
    .io_dmem_rdata (io_dmem_rdata),
    .io_err        (io_err),
    .mem_valid     (mem_valid),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    io_imem_valid = 1'b0; io_imem_addr = '0;
    io_dmem_valid = 1'b0; io_dmem_addr = '0; io_dmem_wdata = '0; io_dmem_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    tick; tick;
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_readies", {io_imem_ready, io_dmem_ready, io_err}, 0);
    reset = 1'b0;
    tick;

    // Lone fetch, memory answers on the first BUSY cycle
    io_imem_valid = 1'b1; io_imem_addr = 32'h100;
    tick;
    check("f1_mem_valid", mem_valid, 1);
    check("f1_mem_addr", mem_addr, 32'h100);
    check("f1_mem_wstrb", mem_wstrb, 0);
    check("f1_early_ready", io_imem_ready, 0);
    mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
    tick;
    check("f1_imem_ready", io_imem_ready, 1);
    check("f1_imem_rdata", io_imem_rdata, 32'h13);
    check("f1_dmem_ready", io_dmem_ready, 0);
    check("f1_err", io_err, 0);
    $display("txn fetch addr=0x100 rdata=0x%08h", io_imem_rdata);
    io_imem_valid = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    tick;
    check("f1_pulse_end", io_imem_ready, 0);

    // Stray mem_ready while idle must do nothing
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick; tick;
    check("idle_ready_ignored", {mem_valid, io_imem_ready, io_dmem_ready, io_err}, 0);
    mem_ready = 1'b0;

    // Simultaneous fetch and store: store first
    io_imem_valid = 1'b1; io_imem_addr = 32'h100;
    io_dmem_valid = 1'b1; io_dmem_addr = 32'h2000; io_dmem_wdata = 32'hDEAD_BEEF; io_dmem_wstrb = 4'hF;
    tick;
    check("both_mem_addr", mem_addr, 32'h2000);
    check("both_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("both_mem_wstrb", mem_wstrb, 4'hF);
    io_dmem_addr = 32'h9999; io_dmem_wdata = 32'h0;
    tick;
    check("capture_once_addr", mem_addr, 32'h2000);
    check("capture_once_wdata", mem_wdata, 32'hDEAD_BEEF);
    mem_ready = 1'b1; mem_rdata = 32'h0;
    tick;
    check("both_dmem_ready", io_dmem_ready, 1);
    check("both_imem_idle", io_imem_ready, 0);
    $display("txn store addr=0x2000 wdata=0xdeadbeef");
    io_dmem_valid = 1'b0; mem_ready = 1'b0;
    tick;
    tick;
    check("both_fetch_addr", mem_addr, 32'h100);
    check("both_fetch_wstrb", mem_wstrb, 0);
    check("both_fetch_wdata", mem_wdata, 0);
    mem_ready = 1'b1; mem_rdata = 32'h1234;
    tick;
    check("both_fetch_ready", io_imem_ready, 1);
    check("both_fetch_rdata", io_imem_rdata, 32'h1234);
    $display("txn fetch addr=0x100 rdata=0x%08h", io_imem_rdata);
    io_imem_valid = 1'b0; mem_ready = 1'b0;
    tick;

    // Starvation bound: grants go D,D,D,D,I repeating
    io_imem_valid = 1'b1; io_imem_addr = 32'h500;
    io_dmem_valid = 1'b1; io_dmem_wstrb = 4'h0; io_dmem_wdata = 32'h0;
    for (int k = 0; k < 10; k++) begin
      logic exp_i;
      exp_i = ((k % 5) == 4);
      io_dmem_addr = 32'h6000 + 32'(k * 4);
      tick;
      check($sformatf("starve%0d_addr", k), mem_addr, exp_i ? 32'h500 : 32'h6000 + 32'(k * 4));
      mem_ready = 1'b1; mem_rdata = 32'(k);
      tick;
      check($sformatf("starve%0d_imem", k), io_imem_ready, {31'b0, exp_i});
      check($sformatf("starve%0d_dmem", k), io_dmem_ready, {31'b0, !exp_i});
      $display("txn starve k=%0d grant=%s addr=0x%08h", k, exp_i ? "imem" : "dmem", mem_addr);
      mem_ready = 1'b0;
      tick;
    end
    io_imem_valid = 1'b0; io_dmem_valid = 1'b0;
    tick;

    // Timeout: eight BUSY cycles with no mem_ready
    io_dmem_valid = 1'b1; io_dmem_addr = 32'h3000; io_dmem_wstrb = 4'h0;
    mem_rdata = 32'hAAAA_5555;
    tick;
    for (int i = 1; i < 8; i++) begin
      tick;
      check($sformatf("to_busy%0d", i), {mem_valid, io_dmem_ready}, 2'b10);
    end
    tick;
    check("to_dmem_ready", io_dmem_ready, 1);
    check("to_dmem_rdata", io_dmem_rdata, 0);
    check("to_err", io_err, 1);
    $display("txn load addr=0x3000 timed out err=%0d", io_err);
    io_dmem_valid = 1'b0;
    tick;
    check("to_err_clear", io_err, 0);

    // Normal transaction after a timeout
    io_dmem_valid = 1'b1; io_dmem_addr = 32'h3004; io_dmem_wdata = 32'h1; io_dmem_wstrb = 4'h3;
    tick; tick;
    mem_ready = 1'b1; mem_rdata = 32'hCAFE;
    tick;
    check("post_to_ready", io_dmem_ready, 1);
    check("post_to_rdata", io_dmem_rdata, 32'hCAFE);
    check("post_to_err", io_err, 0);
    $display("txn store addr=0x3004 after timeout err=%0d", io_err);
    io_dmem_valid = 1'b0; mem_ready = 1'b0;
    tick;

    // mem_ready on the expiry cycle wins over the timeout
    io_dmem_valid = 1'b1; io_dmem_addr = 32'h3008; io_dmem_wstrb = 4'h0;
    tick;
    for (int i = 1; i < 8; i++) tick;
    mem_ready = 1'b1; mem_rdata = 32'h77;
    tick;
    check("edge_ready", io_dmem_ready, 1);
    check("edge_rdata", io_dmem_rdata, 32'h77);
    check("edge_err", io_err, 0);
    $display("txn load addr=0x3008 ready on expiry rdata=0x%08h", io_dmem_rdata);
    io_dmem_valid = 1'b0; mem_ready = 1'b0;
    tick;

    // Reset during BUSY abandons the transaction
    io_imem_valid = 1'b1; io_imem_addr = 32'h700;
    tick;
    check("rb_busy", mem_valid, 1);
    reset = 1'b1;
    tick;
    check("rb_mem_valid", mem_valid, 0);
    check("rb_no_ready", {io_imem_ready, io_dmem_ready, io_err}, 0);
    tick;
    check("rb_hold", {mem_valid, io_imem_ready}, 0);
    reset = 1'b0; io_imem_addr = 32'h800;
    tick;
    check("rb_refetch_addr", mem_addr, 32'h800);
    mem_ready = 1'b1; mem_rdata = 32'h99;
    tick;
    check("rb_refetch_ready", io_imem_ready, 1);
    check("rb_refetch_rdata", io_imem_rdata, 32'h99);
    $display("txn fetch addr=0x800 after reset rdata=0x%08h", io_imem_rdata);
    io_imem_valid = 1'b0; mem_ready = 1'b0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
